// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 load/store codes,
// FSM states and timeout counter sizing.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    function automatic int unsigned to_cnt_w(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks the addressed byte/halfword lane of a read word
// and sign- or zero-extends it according to funct3.
module load_extend
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = rdata[15:0];
        data_c   = rdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      data_c = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LH:      data_c = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LBU:     data_c = {{(WIDTH-8){1'b0}}, byte_sel};
            LHU:     data_c = {{(WIDTH-16){1'b0}}, half_sel};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues data-memory loads/stores over req/ack, stalls the
// upstream pipeline while an access is outstanding and registers MEM/WB results.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] PC,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             stall_o,
    output logic             wb_valid_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic [WIDTH-1:0] ReadData_o,
    output logic [4:0]       rd_o,
    output logic [WIDTH-1:0] PC_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    localparam int unsigned      CNT_W    = to_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             acc_we_q, acc_we_d;
    logic [3:0]       acc_be_q, acc_be_d;
    logic [WIDTH-1:0] acc_wdata_q, acc_wdata_d;
    logic [WIDTH-1:0] acc_alu_q, acc_alu_d;
    logic [2:0]       acc_f3_q, acc_f3_d;
    logic [4:0]       acc_rd_q, acc_rd_d;
    logic [WIDTH-1:0] acc_pc_q, acc_pc_d;
    logic             acc_regwrite_q, acc_regwrite_d;
    logic             acc_memtoreg_q, acc_memtoreg_d;
    logic             wb_valid_q, wb_valid_d;
    logic             regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;

    logic [2:0]       f3;
    logic [1:0]       lo;
    logic             is_mem, legal, aligned, issue_ok, stall_c;
    logic [3:0]       be_c;
    logic [WIDTH-1:0] wdata_c, ext_c;
    logic             unused_instr;

    assign unused_instr = ^{instr[WIDTH-1:15], instr[6:0]};

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .rdata   (mem_rdata),
        .addr_lo (acc_alu_q[1:0]),
        .funct3  (acc_f3_q),
        .data_c  (ext_c)
    );

    // Decode of the instruction sitting in EX/MEM: legality, alignment, lanes.
    always_comb begin
        f3       = instr[14:12];
        lo       = ALU_Result[1:0];
        is_mem   = MemRead | MemWrite;
        legal    = MemWrite ? (f3 inside {SB, SH, SW}) : (f3 inside {LB, LH, LW, LBU, LHU});
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lo[0];
            default: aligned = (lo == 2'b00);
        endcase
        issue_ok = legal & aligned;
        be_c     = 4'b1111;
        wdata_c  = WrData;
        if (MemWrite) begin
            case (f3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << lo;
                    wdata_c = WIDTH'({4{WrData[7:0]}});
                end
                2'b01: begin
                    be_c    = lo[1] ? 4'b1100 : 4'b0011;
                    wdata_c = WIDTH'({2{WrData[15:0]}});
                end
                default: ;
            endcase
        end
    end

    // Next-state and write-back selection; write-back fields default to a bubble.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_req_d      = 1'b0;
        acc_we_d       = acc_we_q;
        acc_be_d       = acc_be_q;
        acc_wdata_d    = acc_wdata_q;
        acc_alu_d      = acc_alu_q;
        acc_f3_d       = acc_f3_q;
        acc_rd_d       = acc_rd_q;
        acc_pc_d       = acc_pc_q;
        acc_regwrite_d = acc_regwrite_q;
        acc_memtoreg_d = acc_memtoreg_q;
        wb_valid_d     = 1'b0;
        regwrite_d     = 1'b0;
        memtoreg_d     = 1'b0;
        alu_d          = '0;
        rdata_d        = '0;
        rd_d           = '0;
        pc_d           = '0;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;
        stall_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && is_mem && issue_ok) begin
                    stall_c        = 1'b1;
                    state_d        = ACCESS;
                    cnt_d          = '0;
                    mem_req_d      = 1'b1;
                    acc_we_d       = MemWrite;
                    acc_be_d       = be_c;
                    acc_wdata_d    = wdata_c;
                    acc_alu_d      = ALU_Result;
                    acc_f3_d       = f3;
                    acc_rd_d       = instr[11:7];
                    acc_pc_d       = PC;
                    acc_regwrite_d = RegWrite;
                    acc_memtoreg_d = MemtoReg;
                end else if (in_valid) begin
                    wb_valid_d = 1'b1;
                    regwrite_d = RegWrite & ~is_mem;
                    misalign_d = is_mem;
                    memtoreg_d = MemtoReg;
                    alu_d      = ALU_Result;
                    rd_d       = instr[11:7];
                    pc_d       = PC;
                end
            end
            ACCESS: begin
                mem_req_d = 1'b1;
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    memtoreg_d = acc_memtoreg_q;
                    alu_d      = acc_alu_q;
                    rd_d       = acc_rd_q;
                    pc_d       = acc_pc_q;
                    if (mem_ack) begin
                        regwrite_d = acc_regwrite_q & ~acc_we_q;
                        rdata_d    = acc_we_q ? '0 : ext_c;
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            acc_we_q       <= 1'b0;
            acc_be_q       <= '0;
            acc_wdata_q    <= '0;
            acc_alu_q      <= '0;
            acc_f3_q       <= '0;
            acc_rd_q       <= '0;
            acc_pc_q       <= '0;
            acc_regwrite_q <= 1'b0;
            acc_memtoreg_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            alu_q          <= '0;
            rdata_q        <= '0;
            rd_q           <= '0;
            pc_q           <= '0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            acc_we_q       <= acc_we_d;
            acc_be_q       <= acc_be_d;
            acc_wdata_q    <= acc_wdata_d;
            acc_alu_q      <= acc_alu_d;
            acc_f3_q       <= acc_f3_d;
            acc_rd_q       <= acc_rd_d;
            acc_pc_q       <= acc_pc_d;
            acc_regwrite_q <= acc_regwrite_d;
            acc_memtoreg_q <= acc_memtoreg_d;
            wb_valid_q     <= wb_valid_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            alu_q          <= alu_d;
            rdata_q        <= rdata_d;
            rd_q           <= rd_d;
            pc_q           <= pc_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // Stall is the only combinational output; held low while reset is asserted.
    assign stall_o      = reset & stall_c;
    assign mem_req      = mem_req_q;
    assign mem_we       = acc_we_q;
    assign mem_addr     = {acc_alu_q[WIDTH-1:2], 2'b00};
    assign mem_be       = acc_be_q;
    assign mem_wdata    = acc_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign RegWrite_o   = regwrite_q;
    assign MemtoReg_o   = memtoreg_q;
    assign ALU_Result_o = alu_q;
    assign ReadData_o   = rdata_q;
    assign rd_o         = rd_q;
    assign PC_o         = pc_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level
// model of loads, stores, alignment, timeout and reset behaviour.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        in_valid, MemtoReg, RegWrite, MemRead, MemWrite;
    logic [31:0] ALU_Result, WrData, instr, PC;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_o, wb_valid_o, RegWrite_o, MemtoReg_o, misalign_o, bus_err_o;
    logic [31:0] ALU_Result_o, ReadData_o, PC_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ALU_Result   (ALU_Result),
        .WrData       (WrData),
        .instr        (instr),
        .PC           (PC),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall_o      (stall_o),
        .wb_valid_o   (wb_valid_o),
        .RegWrite_o   (RegWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .ALU_Result_o (ALU_Result_o),
        .ReadData_o   (ReadData_o),
        .rd_o         (rd_o),
        .PC_o         (PC_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: access size in bytes and whether the access is legal and naturally aligned.
    function automatic int unsigned mdl_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit mdl_ok(input bit wr, input logic [2:0] f3, input logic [1:0] off);
        if (wr && f3 > 3'd2) return 1'b0;
        if (!wr && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
        return (int'(off) % int'(mdl_size(f3))) == 0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        int unsigned v, sz;
        sz = mdl_size(f3);
        v  = w >> (8 * int'(off));
        if (sz < 4) begin
            v = v % (32'd1 << (8 * sz));
            if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        end
        return v;
    endfunction

    task automatic drive(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] pc);
        in_valid   = 1'b1;
        MemRead    = rd_en;
        MemWrite   = wr_en;
        RegWrite   = rw;
        MemtoReg   = m2r;
        ALU_Result = alu;
        WrData     = wd;
        PC         = pc;
        instr      = ($urandom & 32'hFFFF_8000) | (32'(f3) << 12) | (32'(rd) << 7) | ($urandom & 32'h7F);
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
    endtask

    task automatic check_wb(input string tag, input logic rw, input logic m2r, input logic [31:0] alu,
                            input logic [31:0] rdat, input logic [4:0] rd, input logic [31:0] pc,
                            input logic mis, input logic berr);
        check({tag, "_wb_valid"}, wb_valid_o, 1);
        check({tag, "_regwrite"}, RegWrite_o, rw);
        check({tag, "_memtoreg"}, MemtoReg_o, m2r);
        check({tag, "_alu"}, ALU_Result_o, alu);
        check({tag, "_rdata"}, ReadData_o, rdat);
        check({tag, "_rd"}, rd_o, rd);
        check({tag, "_pc"}, PC_o, pc);
        check({tag, "_misalign"}, misalign_o, mis);
        check({tag, "_bus_err"}, bus_err_o, berr);
        check({tag, "_req_done"}, mem_req, 0);
    endtask

    // One instruction through MEM: starts and ends on a falling edge so ops chain back-to-back.
    task automatic run_op(input string tag, input logic rd_en, input logic wr_en, input logic rw,
                          input logic m2r, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                          input int ack_dly, input logic [31:0] rdata);
        bit          mem, ok;
        logic [1:0]  off;
        logic [31:0] ex_be, ex_wd;
        int unsigned sz;
        off = alu[1:0];
        mem = rd_en | wr_en;
        ok  = mdl_ok(wr_en, f3, off);
        sz  = mdl_size(f3);
        drive(rd_en, wr_en, rw, m2r, alu, wd, f3, rd, pc);
        #1;
        check({tag, "_stall_issue"}, stall_o, mem && ok);
        if (!mem || !ok) begin
            @(negedge clk);
            check_wb(tag, mem ? 1'b0 : rw, m2r, alu, 0, rd, pc, mem, 1'b0);
            return;
        end
        ex_be = wr_en ? (((32'd1 << sz) - 1) << off) : 32'hF;
        ex_wd = (sz == 1) ? (wd % 32'h100) * 32'h0101_0101 :
                (sz == 2) ? (wd % 32'h1_0000) * 32'h0001_0001 : wd;
        @(negedge clk);
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            check({tag, "_req"}, mem_req, 1);
            check({tag, "_addr"}, mem_addr, alu & 32'hFFFF_FFFC);
            check({tag, "_be"}, mem_be, ex_be);
            check({tag, "_we"}, mem_we, wr_en);
            if (wr_en) check({tag, "_wdata"}, mem_wdata, ex_wd);
            check({tag, "_wb_busy"}, wb_valid_o, 0);
            if (c == ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                #1;
                check({tag, "_stall_ack"}, stall_o, 0);
                @(negedge clk);
                mem_ack = 1'b0;
                check_wb(tag, wr_en ? 1'b0 : rw, m2r, alu,
                         wr_en ? 32'h0 : mdl_load(rdata, f3, off), rd, pc, 1'b0, 1'b0);
                return;
            end
            #1;
            check({tag, "_stall_wait"}, stall_o, c != int'(TIMEOUT) - 1);
            @(negedge clk);
        end
        check_wb({tag, "_to"}, 1'b0, m2r, alu, 0, rd, pc, 1'b0, 1'b1);
    endtask

    task automatic bubble(input logic ack);
        in_valid   = 1'b0;
        MemRead    = 1'($urandom);
        MemWrite   = 1'($urandom);
        RegWrite   = 1'b1;
        ALU_Result = $urandom & 32'hFFFF_FFFC;
        instr      = $urandom;
        mem_ack    = ack;
        #1;
        check("bubble_stall", stall_o, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("bubble_wb_valid", wb_valid_o, 0);
        check("bubble_regwrite", RegWrite_o, 0);
        check("bubble_req", mem_req, 0);
        check("bubble_misalign", misalign_o, 0);
        check("bubble_bus_err", bus_err_o, 0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        ALU_Result = '0; WrData = '0; instr = '0; PC = '0; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_stall", stall_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_regwrite", RegWrite_o, 0);
        check("rst_misalign", misalign_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("add", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 3'b000, 5'd5, 32'h40, 0, 32'h0);
        check("add_alu_lit", ALU_Result_o, 32'h1234);
        run_op("lb", 1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 3'b000, 5'd6, 32'h44, 2, 32'h80FF_FFFF);
        check("lb_rdata_lit", ReadData_o, 32'hFFFF_FF80);
        run_op("lhu", 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 3'b101, 5'd7, 32'h48, 0, 32'hBEEF_1234);
        check("lhu_rdata_lit", ReadData_o, 32'h0000_BEEF);
        run_op("sh", 1'b0, 1'b1, 1'b1, 1'b0, 32'h206, 32'h0000_ABCD, 3'b001, 5'd8, 32'h4C, 1, 32'h0);
        run_op("lw_mis", 1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, 3'b010, 5'd9, 32'h50, 0, 32'h0);
        bubble(1'b1);
        check("mis_pulse_gone", misalign_o, 0);
        run_op("lw_to", 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 3'b010, 5'd10, 32'h54, 99, 32'h0);
        bubble(1'b0);
        run_op("ld_bad_f3", 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 3'b011, 5'd11, 32'h58, 0, 32'h0);
        run_op("sw", 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'hCAFE_F00D, 3'b010, 5'd0, 32'h5C, 3, 32'h0);

        // Reset in the middle of an outstanding load aborts it asynchronously.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 3'b010, 5'd12, 32'h60);
        @(negedge clk);
        check("arst_pre_req", mem_req, 1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_stall", stall_o, 0);
        check("arst_wb_valid", wb_valid_o, 0);
        check("arst_be", mem_be, 0);
        check("arst_addr", mem_addr, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("arst_post_wb", wb_valid_o, 0);
        check("arst_post_req", mem_req, 0);

        for (int i = 0; i < 200; i++) begin
            int unsigned kind;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          dly;
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom);
            addr = $urandom;
            dly  = ($urandom_range(0, 24) == 0) ? 99 : int'($urandom_range(0, 5));
            if (kind == 0) bubble(1'($urandom));
            else if (kind <= 3)
                run_op("r_alu", 1'b0, 1'b0, 1'($urandom), 1'b0, addr, $urandom, f3, 5'($urandom), $urandom, 0, 0);
            else if (kind <= 6)
                run_op("r_ld", 1'b1, 1'b0, 1'($urandom), 1'b1, addr, $urandom, f3, 5'($urandom), $urandom, dly, $urandom);
            else
                run_op("r_st", 1'b0, 1'b1, 1'($urandom), 1'b0, addr, $urandom, f3, 5'($urandom), $urandom, dly, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
